// File: rtl/ysyx_22050612_lsu_pkg.sv
// Shared encodings for the ysyx_22050612 load/store unit: access sizes, FSM states
// and the per-size byte-enable patterns before they are shifted into their lane.
package ysyx_22050612_lsu_pkg;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } lsu_state_e;

  localparam logic [7:0] MASK_B = 8'h01;
  localparam logic [7:0] MASK_H = 8'h03;
  localparam logic [7:0] MASK_W = 8'h0F;
  localparam logic [7:0] MASK_D = 8'hFF;

  function automatic logic [7:0] base_mask(input logic [1:0] size);
    case (size)
      SZ_B:    base_mask = MASK_B;
      SZ_H:    base_mask = MASK_H;
      SZ_W:    base_mask = MASK_W;
      default: base_mask = MASK_D;
    endcase
  endfunction

endpackage

// File: rtl/ysyx_22050612_lsu_align.sv
// Byte-lane datapath for the LSU: store shift/mask, load extract/extend and the
// natural-alignment check. Purely combinational.
module ysyx_22050612_lsu_align
  import ysyx_22050612_lsu_pkg::*;
(
  input  logic [2:0]  off,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  input  logic [63:0] wdata,
  input  logic [63:0] rdata,
  output logic [63:0] st_wdata,
  output logic [7:0]  st_wmask,
  output logic [63:0] ld_data,
  output logic        misaligned
);

  logic [5:0]  shamt;
  logic [63:0] lane;

  assign shamt    = {off, 3'b000};
  assign lane     = rdata >> shamt;
  assign st_wdata = wdata << shamt;
  assign st_wmask = base_mask(size) << off;

  // A doubleword ignores is_unsigned because there are no bits left to extend.
  always_comb begin
    ld_data    = lane;
    misaligned = 1'b0;
    case (size)
      SZ_B: begin
        ld_data = {{56{~is_unsigned & lane[7]}}, lane[7:0]};
      end
      SZ_H: begin
        ld_data    = {{48{~is_unsigned & lane[15]}}, lane[15:0]};
        misaligned = off[0];
      end
      SZ_W: begin
        ld_data    = {{32{~is_unsigned & lane[31]}}, lane[31:0]};
        misaligned = |off[1:0];
      end
      default: begin
        misaligned = |off;
      end
    endcase
  end

endmodule

// File: rtl/ysyx_22050612_lsu.sv
// Single-outstanding load/store unit between execute and writeback.
// Optional watchdog with stale-response discard: YSYX_22050612_LSU_TIMEOUT_EN.
module ysyx_22050612_lsu
  import ysyx_22050612_lsu_pkg::*;
#(
  parameter int ADDR_W         = 64,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_wen,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [63:0]       in_wdata,
  input  logic [1:0]        in_size,
  input  logic              in_unsigned,
  input  logic [4:0]        in_rd,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [63:0]       out_rdata,
  output logic [4:0]        out_rd,
  output logic              out_err,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wen,
  output logic [63:0]       mem_wdata,
  output logic [7:0]        mem_wmask,
  input  logic              mem_resp_valid,
  input  logic [63:0]       mem_resp_rdata
);

  lsu_state_e  state;
  logic [2:0]  lat_off;
  logic [1:0]  lat_size;
  logic        lat_unsigned;
  logic        lat_wen;
  logic [4:0]  lat_rd;
  logic [2:0]  a_off;
  logic [1:0]  a_size;
  logic        a_unsigned;
  logic [63:0] st_wdata;
  logic [63:0] ld_data;
  logic [7:0]  st_wmask;
  logic        misaligned;
  logic        timeout_hit;
  logic        resp_take;

  // The aligner sees the live request while idle and the latched one afterwards.
  assign a_off      = (state == IDLE) ? in_addr[2:0] : lat_off;
  assign a_size     = (state == IDLE) ? in_size      : lat_size;
  assign a_unsigned = (state == IDLE) ? in_unsigned  : lat_unsigned;

  ysyx_22050612_lsu_align u_align (
    .off        (a_off),
    .size       (a_size),
    .is_unsigned(a_unsigned),
    .wdata      (in_wdata),
    .rdata      (mem_resp_rdata),
    .st_wdata   (st_wdata),
    .st_wmask   (st_wmask),
    .ld_data    (ld_data),
    .misaligned (misaligned)
  );

`ifdef YSYX_22050612_LSU_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 2);
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt;
  logic          stale;

  assign timeout_hit = (cnt >= TO_LAST);
  assign resp_take   = mem_resp_valid & ~stale;

  // A timeout in WAIT leaves a response in flight; the next pulse belongs to it.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= '0;
      stale <= 1'b0;
    end else begin
      if (state == IDLE) cnt <= '0;
      else if (state == REQ || state == WAIT) cnt <= cnt + 1'b1;
      if (state == WAIT && !resp_take && timeout_hit) stale <= 1'b1;
      else if (mem_resp_valid) stale <= 1'b0;
    end
  end
`else
  logic unused_timeout;
  assign timeout_hit    = 1'b0;
  assign resp_take      = mem_resp_valid;
  assign unused_timeout = (TIMEOUT_CYCLES != 0);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      in_ready      <= 1'b1;
      out_valid     <= 1'b0;
      out_rdata     <= '0;
      out_rd        <= '0;
      out_err       <= 1'b0;
      mem_req_valid <= 1'b0;
      mem_addr      <= '0;
      mem_wen       <= 1'b0;
      mem_wdata     <= '0;
      mem_wmask     <= '0;
      lat_off       <= '0;
      lat_size      <= '0;
      lat_unsigned  <= 1'b0;
      lat_wen       <= 1'b0;
      lat_rd        <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          lat_off      <= in_addr[2:0];
          lat_size     <= in_size;
          lat_unsigned <= in_unsigned;
          lat_wen      <= in_wen;
          lat_rd       <= in_rd;
          in_ready     <= 1'b0;
          if (misaligned) begin
            state     <= DONE;
            out_valid <= 1'b1;
            out_err   <= 1'b1;
            out_rdata <= '0;
            out_rd    <= in_wen ? 5'd0 : in_rd;
          end else begin
            state         <= REQ;
            mem_req_valid <= 1'b1;
            mem_addr      <= {in_addr[ADDR_W-1:3], 3'b000};
            mem_wen       <= in_wen;
            mem_wdata     <= in_wen ? st_wdata : 64'd0;
            mem_wmask     <= st_wmask;
          end
        end
        REQ: if (mem_req_ready || timeout_hit) begin
          mem_req_valid <= 1'b0;
          mem_addr      <= '0;
          mem_wen       <= 1'b0;
          mem_wdata     <= '0;
          mem_wmask     <= '0;
          if (mem_req_ready) begin
            state <= WAIT;
          end else begin
            state     <= DONE;
            out_valid <= 1'b1;
            out_err   <= 1'b1;
            out_rdata <= '0;
            out_rd    <= lat_wen ? 5'd0 : lat_rd;
          end
        end
        WAIT: if (resp_take) begin
          state     <= DONE;
          out_valid <= 1'b1;
          out_err   <= 1'b0;
          out_rdata <= lat_wen ? 64'd0 : ld_data;
          out_rd    <= lat_wen ? 5'd0 : lat_rd;
        end else if (timeout_hit) begin
          state     <= DONE;
          out_valid <= 1'b1;
          out_err   <= 1'b1;
          out_rdata <= '0;
          out_rd    <= lat_wen ? 5'd0 : lat_rd;
        end
        DONE: if (out_ready) begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          out_err   <= 1'b0;
          out_rdata <= '0;
          out_rd    <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_22050612_lsu.sv
// Self-checking bench for ysyx_22050612_lsu: directed scenarios plus randomized
// transactions against a byte-level reference model.
module tb_ysyx_22050612_lsu;
  import ysyx_22050612_lsu_pkg::*;

`ifdef YSYX_22050612_LSU_TIMEOUT_EN
  localparam int TO     = 4;
  localparam int BP     = 2;
  localparam int RW_MAX = 1;
`else
  localparam int TO     = 255;
  localparam int BP     = 5;
  localparam int RW_MAX = 3;
`endif

  logic        clk, rst;
  logic        in_valid, in_ready, in_wen, in_unsigned;
  logic [63:0] in_addr, in_wdata;
  logic [1:0]  in_size;
  logic [4:0]  in_rd;
  logic        out_valid, out_ready, out_err;
  logic [63:0] out_rdata;
  logic [4:0]  out_rd;
  logic        mem_req_valid, mem_req_ready, mem_wen, mem_resp_valid;
  logic [63:0] mem_addr, mem_wdata, mem_resp_rdata;
  logic [7:0]  mem_wmask;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic        saw_req;
    logic        unstable;
    int          req_cycles;
    int          latency;
    logic        timed_out;
    logic [63:0] m_addr;
    logic        m_wen;
    logic [63:0] m_wdata;
    logic [7:0]  m_wmask;
    logic [63:0] rdata;
    logic [4:0]  rd;
    logic        err;
  } txn_obs_t;

  ysyx_22050612_lsu #(.ADDR_W(64), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_wen(in_wen), .in_addr(in_addr),
    .in_wdata(in_wdata), .in_size(in_size), .in_unsigned(in_unsigned), .in_rd(in_rd),
    .out_valid(out_valid), .out_ready(out_ready), .out_rdata(out_rdata),
    .out_rd(out_rd), .out_err(out_err),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
    .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_resp_valid(mem_resp_valid), .mem_resp_rdata(mem_resp_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [63:0] ref_load(input logic [63:0] word, input int off,
                                           input int n, input logic uns);
    logic [63:0] v;
    v = '0;
    for (int i = 0; i < n; i++) v[8*i +: 8] = word[8*(off+i) +: 8];
    if (!uns && n < 8 && v[8*n-1])
      for (int i = n; i < 8; i++) v[8*i +: 8] = 8'hFF;
    return v;
  endfunction

  function automatic logic [7:0] ref_mask(input int off, input int n);
    logic [7:0] m;
    m = '0;
    for (int i = 0; i < n && off + i < 8; i++) m[off+i] = 1'b1;
    return m;
  endfunction

  // Drives one request and a responsive memory; leaves the DUT holding its result.
  task automatic run_txn(input logic wen, input logic [63:0] addr, input logic [63:0] wdata,
                         input logic [1:0] size, input logic uns, input logic [4:0] rd,
                         input logic [63:0] resp_word, input int req_wait, input int resp_wait,
                         output txn_obs_t o);
    int   rs;
    logic granted;
    o.saw_req = 0; o.unstable = 0; o.req_cycles = 0; o.m_addr = '0; o.m_wen = 0;
    o.m_wdata = '0; o.m_wmask = '0;
    in_valid = 1'b1; in_wen = wen; in_addr = addr; in_wdata = wdata;
    in_size = size; in_unsigned = uns; in_rd = rd;
    @(negedge clk);
    in_valid = 1'b0;
    o.latency = 1;
    granted = 1'b0;
    rs = 0;
    while (!out_valid && o.latency < 200) begin
      mem_req_ready = 1'b0;
      mem_resp_valid = 1'b0;
      if (mem_req_valid) begin
        if (!o.saw_req) begin
          o.saw_req = 1; o.m_addr = mem_addr; o.m_wen = mem_wen;
          o.m_wdata = mem_wdata; o.m_wmask = mem_wmask;
        end else if (mem_addr !== o.m_addr || mem_wen !== o.m_wen ||
                     mem_wdata !== o.m_wdata || mem_wmask !== o.m_wmask) begin
          o.unstable = 1;
        end
        if (o.req_cycles >= req_wait) begin
          mem_req_ready = 1'b1;
          granted = 1'b1;
        end
        o.req_cycles++;
      end else if (granted) begin
        if (rs == resp_wait) begin
          mem_resp_valid = 1'b1;
          mem_resp_rdata = resp_word;
        end
        rs++;
      end
      @(negedge clk);
      o.latency++;
    end
    mem_req_ready = 1'b0;
    mem_resp_valid = 1'b0;
    o.timed_out = !out_valid;
    o.rdata = out_rdata;
    o.rd = out_rd;
    o.err = out_err;
  endtask

  task automatic complete_out();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_errors++; $display("[TB] FAIL reset_in_ready: got %b expected 1", in_ready);
    end
    n_checks++;
    if ({out_valid, out_err, mem_req_valid, mem_wen} !== 4'b0000) begin
      n_errors++;
      $display("[TB] FAIL reset_flags: got %b expected 0000",
               {out_valid, out_err, mem_req_valid, mem_wen});
    end
    n_checks++;
    if ({out_rdata, out_rd, mem_addr, mem_wdata, mem_wmask} !== '0) begin
      n_errors++; $display("[TB] FAIL reset_data: got %h/%h/%h/%h/%h expected all 0",
                           out_rdata, out_rd, mem_addr, mem_wdata, mem_wmask);
    end
  endtask

  task automatic test_load_byte_signed();
    txn_obs_t o;
    run_txn(1'b0, 64'h8000_0003, 64'h0, SZ_B, 1'b0, 5'd3, 64'h0000_0000_8000_0000, 0, 0, o);
    n_checks++;
    if (o.rdata !== 64'hFFFF_FFFF_FFFF_FF80) begin
      n_errors++; $display("[TB] FAIL lb_rdata: got %h expected ffffffffffffff80", o.rdata);
    end
    n_checks++;
    if (o.err !== 1'b0 || o.rd !== 5'd3) begin
      n_errors++; $display("[TB] FAIL lb_err_rd: got err=%b rd=%0d expected err=0 rd=3", o.err, o.rd);
    end
    n_checks++;
    if (o.latency !== 3) begin
      n_errors++; $display("[TB] FAIL lb_latency: got %0d expected 3", o.latency);
    end
    n_checks++;
    if (o.m_addr !== 64'h8000_0000 || o.m_wen !== 1'b0) begin
      n_errors++; $display("[TB] FAIL lb_mem_addr: got %h wen=%b expected 80000000 wen=0",
                           o.m_addr, o.m_wen);
    end
    complete_out();
  endtask

  task automatic test_load_word_unsigned();
    txn_obs_t o;
    run_txn(1'b0, 64'h8000_0004, 64'h0, SZ_W, 1'b1, 5'd12, 64'h8765_4321_0000_0000, 0, 0, o);
    n_checks++;
    if (o.rdata !== 64'h0000_0000_8765_4321) begin
      n_errors++; $display("[TB] FAIL lwu_rdata: got %h expected 0000000087654321", o.rdata);
    end
    complete_out();
  endtask

  task automatic test_store_half();
    txn_obs_t o;
    run_txn(1'b1, 64'h8000_0006, 64'h0000_0000_0000_ABCD, SZ_H, 1'b0, 5'd7, 64'h0, 0, 0, o);
    n_checks++;
    if (o.m_addr !== 64'h8000_0000) begin
      n_errors++; $display("[TB] FAIL sh_addr: got %h expected 80000000", o.m_addr);
    end
    n_checks++;
    if (o.m_wmask !== 8'hC0 || o.m_wen !== 1'b1) begin
      n_errors++; $display("[TB] FAIL sh_mask: got %h wen=%b expected c0 wen=1", o.m_wmask, o.m_wen);
    end
    n_checks++;
    if (o.m_wdata[63:48] !== 16'hABCD) begin
      n_errors++; $display("[TB] FAIL sh_wdata: got %h expected abcd", o.m_wdata[63:48]);
    end
    n_checks++;
    if (o.rd !== 5'd0 || o.rdata !== 64'd0 || o.err !== 1'b0) begin
      n_errors++; $display("[TB] FAIL sh_result: got rd=%0d rdata=%h err=%b expected 0/0/0",
                           o.rd, o.rdata, o.err);
    end
    complete_out();
  endtask

  task automatic test_misaligned();
    txn_obs_t o;
    logic     bad;
    run_txn(1'b0, 64'h8000_0002, 64'h0, SZ_W, 1'b0, 5'd5, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0, o);
    n_checks++;
    if (o.saw_req !== 1'b0 || o.latency !== 1) begin
      n_errors++; $display("[TB] FAIL mis_noreq: got req=%b latency=%0d expected 0/1",
                           o.saw_req, o.latency);
    end
    n_checks++;
    if (o.err !== 1'b1 || o.rdata !== 64'd0) begin
      n_errors++; $display("[TB] FAIL mis_result: got err=%b rdata=%h expected 1/0", o.err, o.rdata);
    end
    bad = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (out_valid !== 1'b1 || out_err !== 1'b1 || out_rdata !== 64'd0 ||
          out_rd !== o.rd || in_ready !== 1'b0 || mem_req_valid !== 1'b0) bad = 1'b1;
    end
    n_checks++;
    if (bad !== 1'b0) begin
      n_errors++; $display("[TB] FAIL mis_hold: got unstable=%b expected 0", bad);
    end
    complete_out();
  endtask

  task automatic test_backpressure();
    txn_obs_t o;
    run_txn(1'b1, 64'h8000_0108, 64'h1122_3344_5566_7788, SZ_D, 1'b0, 5'd1, 64'h0, BP, 0, o);
    n_checks++;
    if (o.unstable !== 1'b0 || o.req_cycles !== BP + 1) begin
      n_errors++; $display("[TB] FAIL bp_stable: got unstable=%b req_cycles=%0d expected 0/%0d",
                           o.unstable, o.req_cycles, BP + 1);
    end
    n_checks++;
    if (o.m_wdata !== 64'h1122_3344_5566_7788 || o.m_wmask !== 8'hFF ||
        o.m_addr !== 64'h8000_0108) begin
      n_errors++; $display("[TB] FAIL bp_fields: got %h/%h/%h expected 8000_0108/1122334455667788/ff",
                           o.m_addr, o.m_wdata, o.m_wmask);
    end
    n_checks++;
    if (o.latency !== 3 + BP) begin
      n_errors++; $display("[TB] FAIL bp_latency: got %0d expected %0d", o.latency, 3 + BP);
    end
    complete_out();
  endtask

  task automatic test_reset_mid();
    logic bad;
    in_valid = 1'b1; in_wen = 1'b0; in_addr = 64'h8000_0010; in_size = SZ_D;
    in_unsigned = 1'b0; in_rd = 5'd9;
    @(negedge clk);
    in_valid = 1'b0;
    n_checks++;
    if (mem_req_valid !== 1'b1) begin
      n_errors++; $display("[TB] FAIL rstmid_req: got %b expected 1", mem_req_valid);
    end
    mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || mem_req_valid !== 1'b0) begin
      n_errors++; $display("[TB] FAIL rstmid_idle: got in_ready=%b out_valid=%b req=%b expected 1/0/0",
                           in_ready, out_valid, mem_req_valid);
    end
    mem_resp_valid = 1'b1;
    mem_resp_rdata = 64'hDEAD_BEEF_DEAD_BEEF;
    @(negedge clk);
    mem_resp_valid = 1'b0;
    bad = 1'b0;
    repeat (3) begin
      if (out_valid !== 1'b0 || in_ready !== 1'b1) bad = 1'b1;
      @(negedge clk);
    end
    n_checks++;
    if (bad !== 1'b0) begin
      n_errors++; $display("[TB] FAIL rstmid_late_resp: got spurious=%b expected 0", bad);
    end
  endtask

  task automatic test_random();
    txn_obs_t    o;
    logic        wen, uns, mis;
    logic [1:0]  size;
    logic [4:0]  rd;
    logic [63:0] addr, wdata, word, exp_rdata;
    int          n, off, rqw, rsw;
    for (int k = 0; k < 40; k++) begin
      wen  = 1'($urandom_range(0, 1));
      uns  = 1'($urandom_range(0, 1));
      size = 2'($urandom_range(0, 3));
      rd   = 5'($urandom_range(1, 31));
      n    = 1 << size;
      off  = $urandom_range(0, 7);
      if ($urandom_range(0, 2) != 0) off = off - (off % n);
      addr  = 64'h8000_0000 + 64'(($urandom_range(0, 511)) * 8 + off);
      wdata = {$urandom, $urandom};
      word  = {$urandom, $urandom};
      rqw   = $urandom_range(0, RW_MAX);
      rsw   = $urandom_range(0, RW_MAX);
      mis   = (off % n) != 0;
      exp_rdata = (mis || wen) ? 64'd0 : ref_load(word, off, n, uns);
      run_txn(wen, addr, wdata, size, uns, rd, word, rqw, rsw, o);
      n_checks++;
      if (o.timed_out !== 1'b0 || o.err !== mis || o.rdata !== exp_rdata) begin
        n_errors++; $display("[TB] FAIL rnd%0d_result: got to=%b err=%b rdata=%h expected 0/%b/%h",
                             k, o.timed_out, o.err, o.rdata, mis, exp_rdata);
      end
      n_checks++;
      if (o.rd !== (wen ? 5'd0 : rd) || o.saw_req !== !mis) begin
        n_errors++; $display("[TB] FAIL rnd%0d_rd_req: got rd=%0d req=%b expected %0d/%b",
                             k, o.rd, o.saw_req, wen ? 5'd0 : rd, !mis);
      end
      n_checks++;
      if (o.latency !== (mis ? 1 : 3 + rqw + rsw)) begin
        n_errors++; $display("[TB] FAIL rnd%0d_latency: got %0d expected %0d",
                             k, o.latency, mis ? 1 : 3 + rqw + rsw);
      end
      if (!mis) begin
        n_checks++;
        if (o.m_addr !== (addr & ~64'h7) || o.m_wen !== wen || o.unstable !== 1'b0) begin
          n_errors++; $display("[TB] FAIL rnd%0d_mem: got %h wen=%b unst=%b expected %h wen=%b unst=0",
                               k, o.m_addr, o.m_wen, o.unstable, addr & ~64'h7, wen);
        end
        if (wen) begin
          n_checks++;
          if (o.m_wmask !== ref_mask(off, n) || o.m_wdata !== (wdata << (8 * off))) begin
            n_errors++; $display("[TB] FAIL rnd%0d_store: got %h/%h expected %h/%h", k,
                                 o.m_wmask, o.m_wdata, ref_mask(off, n), wdata << (8 * off));
          end
        end
      end
      complete_out();
    end
  endtask

`ifdef YSYX_22050612_LSU_TIMEOUT_EN
  task automatic test_timeout();
    txn_obs_t o;
    logic     bad;
    run_txn(1'b0, 64'h8000_0020, 64'h0, SZ_D, 1'b0, 5'd4, 64'h0, 0, 1000, o);
    n_checks++;
    if (o.err !== 1'b1 || o.rdata !== 64'd0 || o.latency !== 1 + TO) begin
      n_errors++; $display("[TB] FAIL to_first: got err=%b rdata=%h latency=%0d expected 1/0/%0d",
                           o.err, o.rdata, o.latency, 1 + TO);
    end
    complete_out();
    run_txn(1'b0, 64'h8000_0028, 64'h0, SZ_D, 1'b0, 5'd6, 64'h5555_AAAA_5555_AAAA, 0, 0, o);
    n_checks++;
    if (o.err !== 1'b1 || o.rdata !== 64'd0 || o.latency !== 1 + TO) begin
      n_errors++; $display("[TB] FAIL to_stale_wait: got err=%b rdata=%h latency=%0d expected 1/0/%0d",
                           o.err, o.rdata, o.latency, 1 + TO);
    end
    complete_out();
    mem_resp_valid = 1'b1;
    mem_resp_rdata = 64'h0BAD_0BAD_0BAD_0BAD;
    @(negedge clk);
    mem_resp_valid = 1'b0;
    bad = 1'b0;
    repeat (2) begin
      if (out_valid !== 1'b0) bad = 1'b1;
      @(negedge clk);
    end
    n_checks++;
    if (bad !== 1'b0) begin
      n_errors++; $display("[TB] FAIL to_late_idle: got spurious=%b expected 0", bad);
    end
    run_txn(1'b0, 64'h8000_0032, 64'h0, SZ_H, 1'b0, 5'd8, 64'h0000_0000_F00D_0000, 0, 0, o);
    n_checks++;
    if (o.err !== 1'b0 || o.rdata !== 64'hFFFF_FFFF_FFFF_F00D || o.latency !== 3) begin
      n_errors++; $display("[TB] FAIL to_recover: got err=%b rdata=%h latency=%0d expected 0/fffffffffffff00d/3",
                           o.err, o.rdata, o.latency);
    end
    complete_out();
  endtask
`endif

  initial begin
    in_valid = 0; in_wen = 0; in_addr = '0; in_wdata = '0; in_size = '0;
    in_unsigned = 0; in_rd = '0; out_ready = 0; mem_req_ready = 0;
    mem_resp_valid = 0; mem_resp_rdata = '0;
    test_reset();
    test_load_byte_signed();
    test_load_word_unsigned();
    test_store_half();
    test_misaligned();
    test_backpressure();
    test_reset_mid();
    test_random();
`ifdef YSYX_22050612_LSU_TIMEOUT_EN
    test_timeout();
`endif
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
